// File: rtl/tdc_stream_sequencer.sv
// TDC first-hit capture and pixel-ordered streamer feeding the histogram builder.
// Optional feature macro: TDC_GRAY_EN (Gray-coded tdcData lanes converted to binary before capture).
module tdc_stream_sequencer #(
    parameter int NP        = 10,
    parameter int PIXEL_NUM = 6,
    parameter int ACQ_NUM   = 2,
    parameter int WIN_CYC   = 16
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    frameStart,
    input  logic                    acqStart,
    input  logic [PIXEL_NUM-1:0]    tdcValid,
    input  logic [PIXEL_NUM*NP-1:0] tdcData,
    output logic                    wrEn,
    output logic [NP-1:0]           data,
    output logic                    busy,
    output logic                    frameDone,
    output logic                    overrun
);

    localparam int WW = (WIN_CYC   > 1) ? $clog2(WIN_CYC)   : 1;
    localparam int PW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
    localparam int AW = (ACQ_NUM   > 1) ? $clog2(ACQ_NUM)   : 1;

    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYC - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_NUM - 1);
    localparam logic [AW-1:0] ACQ_LAST = AW'(ACQ_NUM - 1);

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, STREAM, DONE} state_t;

    state_t                state;
    logic [WW-1:0]         win_cnt;
    logic [PW-1:0]         pix_cnt;
    logic [AW-1:0]         acq_cnt;
    logic [PIXEL_NUM-1:0]  hit_flag;
    logic [NP-1:0]         ts       [PIXEL_NUM];
    logic [NP-1:0]         lane_bin [PIXEL_NUM];

    function automatic logic [NP-1:0] gray_to_bin(input logic [NP-1:0] g);
        logic [NP-1:0] b;
        b[NP-1] = g[NP-1];
        for (int i = NP - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    always_comb begin
        for (int p = 0; p < PIXEL_NUM; p++) begin
`ifdef TDC_GRAY_EN
            lane_bin[p] = gray_to_bin(tdcData[p*NP +: NP]);
`else
            lane_bin[p] = tdcData[p*NP +: NP];
`endif
        end
    end

    // NOTE: timestamp storage carries no reset; hit_flag masks any stale content.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            for (int p = 0; p < PIXEL_NUM; p++) begin
                if (tdcValid[p] && !hit_flag[p]) ts[p] <= lane_bin[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state     <= IDLE;
            wrEn      <= 1'b0;
            data      <= '0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            overrun   <= 1'b0;
            win_cnt   <= '0;
            pix_cnt   <= '0;
            acq_cnt   <= '0;
            hit_flag  <= '0;
        end else begin
            wrEn      <= 1'b0;
            frameDone <= 1'b0;
            busy      <= (state != IDLE);
            if (acqStart && (state inside {CAPTURE, STREAM, DONE})) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frameStart) begin
                        state   <= ARM;
                        acq_cnt <= '0;
                        overrun <= 1'b0;
                    end
                end
                ARM: begin
                    if (acqStart) begin
                        state    <= CAPTURE;
                        win_cnt  <= '0;
                        hit_flag <= '0;
                    end
                end
                CAPTURE: begin
                    win_cnt <= win_cnt + 1'b1;
                    for (int p = 0; p < PIXEL_NUM; p++) begin
                        if (tdcValid[p]) hit_flag[p] <= 1'b1;
                    end
                    if (win_cnt == WIN_LAST) begin
                        state   <= STREAM;
                        pix_cnt <= '0;
                    end
                end
                STREAM: begin
                    wrEn    <= 1'b1;
                    data    <= hit_flag[pix_cnt] ? ts[pix_cnt] : {NP{1'b1}};
                    pix_cnt <= pix_cnt + 1'b1;
                    if (pix_cnt == PIX_LAST) begin
                        if (acq_cnt == ACQ_LAST) begin
                            state <= DONE;
                        end else begin
                            acq_cnt <= acq_cnt + 1'b1;
                            state   <= ARM;
                        end
                    end
                end
                DONE: begin
                    frameDone <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// Directed self-checking bench for tdc_stream_sequencer; TDC_GRAY_EN selects Gray-coded stimulus.
module tb_tdc_stream_sequencer;

    localparam int NP        = 10;
    localparam int PIXEL_NUM = 6;
    localparam int ACQ_NUM   = 2;
    localparam int WIN_CYC   = 16;

    logic                    clk = 1'b0;
    logic                    res;
    logic                    frameStart;
    logic                    acqStart;
    logic [PIXEL_NUM-1:0]    tdcValid;
    logic [PIXEL_NUM*NP-1:0] tdcData;
    logic                    wrEn;
    logic [NP-1:0]           data;
    logic                    busy;
    logic                    frameDone;
    logic                    overrun;

    int tests = 0;
    int fails = 0;

    tdc_stream_sequencer #(
        .NP(NP), .PIXEL_NUM(PIXEL_NUM), .ACQ_NUM(ACQ_NUM), .WIN_CYC(WIN_CYC)
    ) dut (
        .clk(clk), .res(res), .frameStart(frameStart), .acqStart(acqStart),
        .tdcValid(tdcValid), .tdcData(tdcData), .wrEn(wrEn), .data(data),
        .busy(busy), .frameDone(frameDone), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [NP-1:0] enc(input int v);
        logic [NP-1:0] b;
        b = NP'(v);
`ifdef TDC_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    initial begin
        int acq1_vals [PIXEL_NUM] = '{108, 511, 1022, 200, 90, 600};
        int acq2_vals [PIXEL_NUM] = '{300, 500, 50, 1000, 48, 90};
        int acq2_exp  [PIXEL_NUM] = '{300, 500, 50, 1000, 1023, 90};
        int rst_vals  [PIXEL_NUM] = '{0, 2, 3, 4, 5, 6};
        logic saw_activity;

        res = 1'b0; frameStart = 1'b0; acqStart = 1'b0; tdcValid = '0; tdcData = '0;
        tick(2);
        check("rst_wrEn", wrEn, 0);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_frameDone", frameDone, 0);
        check("rst_overrun", overrun, 0);

        res = 1'b1;
        acqStart = 1'b1;            // ignored in IDLE, must not set overrun
        tick();
        acqStart = 1'b0;
        check("idle_acq_no_overrun", overrun, 0);
        check("idle_busy", busy, 0);

        // Frame 1, acquisition 1: every pixel hits once on the first window cycle
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        tick();
        check("arm_busy", busy, 1);
        acqStart = 1'b1;
        tick();
        acqStart = 1'b0;
        tdcValid = '1;
        for (int p = 0; p < PIXEL_NUM; p++) tdcData[p*NP +: NP] = enc(acq1_vals[p]);
        tick();
        tdcValid = '0;
        tick(WIN_CYC - 1);
        check("acq1_no_early_wrEn", wrEn, 0);
        for (int i = 0; i < PIXEL_NUM; i++) begin
            tick();
            check($sformatf("acq1_wrEn%0d", i), wrEn, 1);
            check($sformatf("acq1_word%0d", i), data, acq1_vals[i]);
        end
        tick();
        check("acq1_end_wrEn", wrEn, 0);
        check("acq1_data_hold", data, 600);
        check("acq1_no_frameDone", frameDone, 0);

        // Acquisition 2: pixel 2 hits twice, pixel 4 never, pixel 0 late hit ignored
        acqStart = 1'b1;
        tick();
        acqStart = 1'b0;
        tdcValid = 6'b101111;
        for (int p = 0; p < PIXEL_NUM; p++) tdcData[p*NP +: NP] = enc(acq2_vals[p]);
        tick();
        tdcValid = 6'b000101;
        tdcData[0*NP +: NP] = enc(7);
        tdcData[2*NP +: NP] = enc(300);
        tick();
        tdcValid = '0;
        tick(WIN_CYC - 2);
        check("acq2_no_early_wrEn", wrEn, 0);
        for (int i = 0; i < PIXEL_NUM; i++) begin
            tick();
            acqStart = 1'b0;
            check($sformatf("acq2_wrEn%0d", i), wrEn, 1);
            check($sformatf("acq2_word%0d", i), data, acq2_exp[i]);
            if (i == 1) acqStart = 1'b1;  // dropped during STREAM, flags overrun
        end
        check("overrun_set", overrun, 1);
        tick();
        check("frameDone_pulse", frameDone, 1);
        check("done_wrEn", wrEn, 0);
        check("done_busy", busy, 1);
        tick();
        check("frameDone_single", frameDone, 0);
        check("busy_fall", busy, 0);
        check("overrun_held", overrun, 1);

        // Frame 2: frameStart clears overrun; reset during the third word
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        check("overrun_cleared", overrun, 0);
        acqStart = 1'b1;
        tick();
        acqStart = 1'b0;
        tdcValid = '1;
        for (int p = 0; p < PIXEL_NUM; p++) tdcData[p*NP +: NP] = enc(rst_vals[p]);
        tdcData[0*NP +: NP] = 10'h3FF;
        tick();
        tdcValid = '0;
        tick(WIN_CYC - 1);
        tick();
`ifdef TDC_GRAY_EN
        check("gray_word0", data, 10'h2AA);
`else
        check("bin_word0", data, 10'h3FF);
`endif
        tick(2);
        check("rst_word2_wrEn", wrEn, 1);
        check("rst_word2", data, 3);
        res = 1'b0;
        tick();
        res = 1'b1;
        check("midrst_wrEn", wrEn, 0);
        check("midrst_data", data, 0);
        check("midrst_busy", busy, 0);
        saw_activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wrEn || frameDone || busy) saw_activity = 1'b1;
        end
        check("midrst_stays_idle", saw_activity, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tdc_stream_sequencer.md
# tdc_stream_sequencer

Front-end producer for the histogram builder: captures one first-hit timestamp per pixel from `PIXEL_NUM` TDC channels during a gated acquisition window, then serialises them pixel-ordered onto the builder's `wrEn`/`data` write interface, one word per clock. It repeats this for `ACQ_NUM` acquisitions per frame and signals frame completion. It sits between the TDC array and `hisBuilderFSM`, replacing the file-driven stimulus used in bench-level builder tests.

## Interface
- `NP`, 10: timestamp width in bits; matches builder `data` width.
- `PIXEL_NUM`, 6: pixels per acquisition, i.e. words streamed per acquisition.
- `ACQ_NUM`, 2: acquisitions per frame.
- `WIN_CYC`, 16: capture window length in clocks, ≥1.
- `clk` in 1: single clock, rising edge.
- `res` in 1: synchronous, active-low reset.
- `frameStart` in 1: pulse; starts a frame from IDLE and clears `overrun`.
- `acqStart` in 1: pulse; opens a capture window when in ARM.
- `tdcValid` in PIXEL_NUM: per-pixel hit strobe.
- `tdcData` in PIXEL_NUM*NP: flat timestamps; pixel p at `[p*NP +: NP]`.
- `wrEn` out 1: write strobe to builder.
- `data` out NP: timestamp word; valid only while `wrEn`=1.
- `busy` out 1: high in every state except IDLE.
- `frameDone` out 1: single-cycle pulse after the last word of the frame.
- `overrun` out 1: sticky; `acqStart` seen outside ARM during a frame.

## Operation
- States: IDLE, ARM, CAPTURE, STREAM, DONE.
- IDLE: `frameStart` → ARM; `acqCnt`←0; `overrun`←0. `acqStart` in IDLE is ignored and does not set `overrun`.
- ARM: `acqStart` → CAPTURE; `winCnt`←0; all `hitFlag`←0.
- CAPTURE: `winCnt` increments each cycle. For each pixel p, if `tdcValid[p]` is high and `hitFlag[p]`=0, then `ts[p]`←`tdcData[p]` and `hitFlag[p]`←1. Later hits on p in the same window are ignored (first-hit wins). The window covers exactly `WIN_CYC` cycles, last cycle inclusive. Next state is STREAM with `pixCnt`←0.
- STREAM: each cycle `wrEn`=1 and `data`=`hitFlag[pixCnt] ? ts[pixCnt] : {NP{1'b1}}`. The no-hit code is all ones (1023 at NP=10). After `pixCnt`=PIXEL_NUM-1:
  - if `acqCnt`=ACQ_NUM-1 → DONE;
  - otherwise `acqCnt`++ and → ARM.
- DONE: `frameDone`=1 for one cycle, then → IDLE.
- `tdcValid` outside CAPTURE is ignored.
- `acqStart` in CAPTURE, STREAM or DONE is dropped and sets `overrun`. `frameStart` outside IDLE is ignored.
- Counters are sized `$clog2` of their bound, minimum 1 bit. Comparisons are against the bound minus 1. There is no wrap: every counter reloads on state entry.

## Timing
- Reset (`res`=0 at a clock edge): next cycle state=IDLE, `wrEn`=0, `data`=0, `busy`=0, `frameDone`=0, `overrun`=0, all counters and `hitFlag` = 0. `ts` registers are not reset.
- Reset mid-STREAM truncates the burst immediately. The builder sees no further `wrEn`.
- All outputs are registered.
- `acqStart` sampled at edge k → CAPTURE active in cycles k+1 … k+WIN_CYC.
- First `wrEn` at cycle k+WIN_CYC+1. Then exactly PIXEL_NUM back-to-back `wrEn` cycles, pixel 0 first.
- Earliest next `acqStart` is accepted at the cycle after the last `wrEn`, when the block is in ARM.
- `frameDone` is asserted in the cycle after the final `wrEn`. `busy` falls in the following cycle.
- `data` holds its last value when `wrEn`=0. No backpressure: the builder must accept one word per clock.

## Configuration
- `TDC_GRAY_EN`:
  - Defined: `tdcData` lanes are Gray-coded. Each lane is converted to binary combinationally before the capture register. Latency is unchanged, and the no-hit code is still all-ones binary.
  - Undefined: lanes are captured as plain binary.

## Test plan
- Reset then `frameStart`, `acqStart`; pixels 0..5 hit once with 108, 511, 1022, 200, 90, 600 → six consecutive `wrEn` words in that order, first at acqStart+17 cycles.
- Pixel 2 hits 50 then 300 in the same window; pixel 4 never hits → word2=50, word4=1023.
- ACQ_NUM=2 full frame with second-acquisition values 300, 500, 50, 1000, 48, 90 → 12 words total; `frameDone` pulses once, one cycle after word 12; `busy` low the cycle after.
- `acqStart` pulsed during STREAM → burst unaffected, `overrun`=1 and held until the next `frameStart`.
- `res`=0 during the third word → `wrEn`=0 the next cycle, state IDLE, no `frameDone`.
- `TDC_GRAY_EN` build, pixel 0 driven Gray 0x3FF → `data`=0x2AA.
